// File: rtl/udma_l2_req_pkg.sv
// Shared types and helpers for the uDMA L2 request stage: access-size encoding and byte-enable generation.
package udma_l2_req_pkg;

    typedef enum logic [1:0] {
        DS_BYTE = 2'b00,
        DS_HALF = 2'b01,
        DS_WORD = 2'b10,
        DS_RSVD = 2'b11
    } ds_e;

    // The reserved size is treated like a full word.
    function automatic logic [3:0] be_calc(input ds_e ds, input logic [1:0] off);
        logic [3:0] be;
        case (ds)
            DS_BYTE: be = 4'b0001 << off;
            DS_HALF: be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/udma_id_fifo.sv
// In-order ID FIFO for outstanding L2 transactions; head is visible combinationally, push/pop take effect next edge.
// Push is accepted when not full or when popping in the same cycle; pop on empty is ignored.
module udma_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/udma_l2_req_stage.sv
// uDMA L2 request stage: grant capture -> L2 request in 1 cycle, response -> channel in 1 cycle; stalls grants while L2 holds off or OUTST_DEPTH is reached.
// Optional perf counters under `UDMA_L2_REQ_PERF_EN; otherwise the perf ports are tied to 0.
module udma_l2_req_stage
    import udma_l2_req_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int L2_AWIDTH   = 19,
    parameter int L2_DWIDTH   = 32,
    parameter int OUTST_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_CH-1:0]           ch_req_i,
    input  logic [N_CH*L2_AWIDTH-1:0] ch_addr_i,
    input  logic [N_CH*2-1:0]         ch_datasize_i,
    output logic [N_CH-1:0]           ch_gnt_o,
    output logic [N_CH-1:0]           ch_rvalid_o,
    output logic [L2_DWIDTH-1:0]      ch_rdata_o,
    output logic [N_CH-1:0]           arb_req_o,
    input  logic [N_CH-1:0]           arb_grant_i,
    input  logic                      arb_any_grant_i,
    output logic                      arb_grant_ack_o,
    output logic                      l2_req_o,
    input  logic                      l2_gnt_i,
    output logic [L2_AWIDTH-1:0]      l2_addr_o,
    output logic [3:0]                l2_be_o,
    input  logic                      l2_rvalid_i,
    input  logic [L2_DWIDTH-1:0]      l2_rdata_i,
    output logic                      err_o,
    output logic [31:0]               perf_gnt_cnt_o,
    output logic [31:0]               perf_stall_cnt_o
);

    localparam int CH_IDW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNTW   = $clog2(OUTST_DEPTH) + 1;
    localparam logic [CNTW:0] DEPTH_L = (CNTW+1)'(OUTST_DEPTH);

    logic                 l2_req_q, l2_req_d;
    logic [L2_AWIDTH-1:0] l2_addr_q, l2_addr_d;
    logic [3:0]           l2_be_q, l2_be_d;
    logic [CH_IDW-1:0]    id_q, id_d;
    logic [N_CH-1:0]      ch_rvalid_q, ch_rvalid_d;
    logic [L2_DWIDTH-1:0] ch_rdata_q, ch_rdata_d;
    logic                 err_q, err_d;

    logic [CH_IDW-1:0]    gnt_idx;
    logic [L2_AWIDTH-1:0] sel_addr;
    logic [1:0]           sel_ds;
    logic [CH_IDW-1:0]    fifo_head;
    logic [CNTW-1:0]      fifo_count;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop, slot_free, room, capture;
    logic [CNTW:0]        outst;

    // Lowest set grant bit wins if the arbiter ever violates one-hot.
    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_ds   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (arb_grant_i[i]) begin
                gnt_idx  = CH_IDW'(i);
                sel_addr = ch_addr_i[i*L2_AWIDTH +: L2_AWIDTH];
                sel_ds   = ch_datasize_i[i*2 +: 2];
            end
        end
    end

    assign push      = l2_req_q & l2_gnt_i;
    assign pop       = l2_rvalid_i & ~fifo_empty;
    assign slot_free = ~l2_req_q | l2_gnt_i;
    assign outst     = {1'b0, fifo_count} + {{CNTW{1'b0}}, l2_req_q};
    assign room      = (outst < DEPTH_L) | pop;
    assign capture   = arb_any_grant_i & slot_free & room;

    assign arb_grant_ack_o = capture;
    assign ch_gnt_o        = capture ? arb_grant_i : '0;
    assign arb_req_o       = ch_req_i & ~ch_gnt_o;

    always_comb begin
        l2_req_d    = l2_req_q;
        l2_addr_d   = l2_addr_q;
        l2_be_d     = l2_be_q;
        id_d        = id_q;
        ch_rvalid_d = '0;
        ch_rdata_d  = ch_rdata_q;
        err_d       = err_q;
        if (capture) begin
            l2_req_d  = 1'b1;
            l2_addr_d = {sel_addr[L2_AWIDTH-1:2], 2'b00};
            l2_be_d   = be_calc(ds_e'(sel_ds), sel_addr[1:0]);
            id_d      = gnt_idx;
        end else if (l2_gnt_i) begin
            l2_req_d  = 1'b0;
        end
        if (pop) begin
            ch_rvalid_d = N_CH'(1) << fifo_head;
            ch_rdata_d  = l2_rdata_i;
        end
        if (l2_rvalid_i & fifo_empty) err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            l2_req_q    <= 1'b0;
            l2_addr_q   <= '0;
            l2_be_q     <= '0;
            id_q        <= '0;
            ch_rvalid_q <= '0;
            ch_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            l2_req_q    <= l2_req_d;
            l2_addr_q   <= l2_addr_d;
            l2_be_q     <= l2_be_d;
            id_q        <= id_d;
            ch_rvalid_q <= ch_rvalid_d;
            ch_rdata_q  <= ch_rdata_d;
            err_q       <= err_d;
        end
    end

    assign l2_req_o    = l2_req_q;
    assign l2_addr_o   = l2_addr_q;
    assign l2_be_o     = l2_be_q;
    assign ch_rvalid_o = ch_rvalid_q;
    assign ch_rdata_o  = ch_rdata_q;
    assign err_o       = err_q;

    udma_id_fifo #(
        .DEPTH (OUTST_DEPTH),
        .WIDTH (CH_IDW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (id_q),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef UDMA_L2_REQ_PERF_EN
    logic [31:0] perf_gnt_q, perf_gnt_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        perf_gnt_d   = perf_gnt_q;
        perf_stall_d = perf_stall_q;
        if (capture && perf_gnt_q != '1)                     perf_gnt_d   = perf_gnt_q + 32'd1;
        if (l2_req_q && !l2_gnt_i && perf_stall_q != '1)     perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_gnt_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_gnt_q   <= perf_gnt_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_gnt_cnt_o   = perf_gnt_q;
    assign perf_stall_cnt_o = perf_stall_q;
`else
    assign perf_gnt_cnt_o   = '0;
    assign perf_stall_cnt_o = '0;
`endif

endmodule
